// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and helpers for the four-way traffic-light controller.
//   - state_e    : controller states (clearance states only with
//                  TRAFFIC_ALL_RED_EN defined)
//   - dir_e      : approach directions in round-robin order N, S, E, W
//   - LAMP_*     : one-hot lamp encodings {red, yellow, green}
//   - next_dir   : round-robin successor of a direction
//   - dir_of     : direction served by a green/yellow/clearance state
//   - green_state/yellow_state/clr_state : state for a given direction
//   - lamps_of   : lamp pattern {north, south, east, west} for a state
// Configuration macro: TRAFFIC_ALL_RED_EN (adds all-red clearance states).
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam logic [11:0] LAMPS_ALL_RED = {LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED};

    typedef enum logic [3:0] {
        INIT     = 4'd0,
        N_GREEN  = 4'd1,
        N_YELLOW = 4'd2,
        S_GREEN  = 4'd3,
        S_YELLOW = 4'd4,
        E_GREEN  = 4'd5,
        E_YELLOW = 4'd6,
        W_GREEN  = 4'd7,
`ifdef TRAFFIC_ALL_RED_EN
        W_YELLOW = 4'd8,
        N_CLR    = 4'd9,
        S_CLR    = 4'd10,
        E_CLR    = 4'd11,
        W_CLR    = 4'd12
`else
        W_YELLOW = 4'd8
`endif
    } state_e;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_S = 2'd1,
        DIR_E = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    function automatic dir_e next_dir(input dir_e d);
        dir_e r;
        case (d)
            DIR_N:   r = DIR_S;
            DIR_S:   r = DIR_E;
            DIR_E:   r = DIR_W;
            DIR_W:   r = DIR_N;
            default: r = DIR_N;
        endcase
        return r;
    endfunction

    // INIT and illegal encodings map to north; callers never use the
    // direction of those states.
    function automatic dir_e dir_of(input state_e s);
        dir_e r;
        case (s)
            S_GREEN, S_YELLOW: r = DIR_S;
            E_GREEN, E_YELLOW: r = DIR_E;
            W_GREEN, W_YELLOW: r = DIR_W;
`ifdef TRAFFIC_ALL_RED_EN
            S_CLR:             r = DIR_S;
            E_CLR:             r = DIR_E;
            W_CLR:             r = DIR_W;
`endif
            default:           r = DIR_N;
        endcase
        return r;
    endfunction

    function automatic state_e green_state(input dir_e d);
        state_e r;
        case (d)
            DIR_N:   r = N_GREEN;
            DIR_S:   r = S_GREEN;
            DIR_E:   r = E_GREEN;
            DIR_W:   r = W_GREEN;
            default: r = INIT;
        endcase
        return r;
    endfunction

    function automatic state_e yellow_state(input dir_e d);
        state_e r;
        case (d)
            DIR_N:   r = N_YELLOW;
            DIR_S:   r = S_YELLOW;
            DIR_E:   r = E_YELLOW;
            DIR_W:   r = W_YELLOW;
            default: r = INIT;
        endcase
        return r;
    endfunction

`ifdef TRAFFIC_ALL_RED_EN
    function automatic state_e clr_state(input dir_e d);
        state_e r;
        case (d)
            DIR_N:   r = N_CLR;
            DIR_S:   r = S_CLR;
            DIR_E:   r = E_CLR;
            DIR_W:   r = W_CLR;
            default: r = INIT;
        endcase
        return r;
    endfunction
`endif

    // Lamp pattern {north, south, east, west}. Anything that is not a green
    // or yellow state (INIT, clearance, illegal) shows all red.
    function automatic logic [11:0] lamps_of(input state_e s);
        logic [11:0] r;
        r = LAMPS_ALL_RED;
        case (s)
            N_GREEN:  r[11:9] = LAMP_GREEN;
            N_YELLOW: r[11:9] = LAMP_YELLOW;
            S_GREEN:  r[8:6]  = LAMP_GREEN;
            S_YELLOW: r[8:6]  = LAMP_YELLOW;
            E_GREEN:  r[5:3]  = LAMP_GREEN;
            E_YELLOW: r[5:3]  = LAMP_YELLOW;
            W_GREEN:  r[2:0]  = LAMP_GREEN;
            W_YELLOW: r[2:0]  = LAMP_YELLOW;
            default:  r = LAMPS_ALL_RED;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// traffic_phase_timer
// 8-bit phase counter. Clears on request, otherwise counts up every cycle.
// done flags the last cycle of a phase (count == duration - 1), so a phase
// with duration D lasts exactly D cycles when the owner clears on done.
// Ports:
//   clk      in  clock, rising edge
//   rst_n    in  asynchronous active-low reset (count -> 0)
//   clear    in  synchronous clear of the count (state change)
//   duration in  [7:0] length of the current phase, 1..255
//   done     out current cycle is the last of the phase
// -----------------------------------------------------------------------------
module traffic_phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [7:0] duration,
    output logic       done
);

    logic [7:0] count_r;

    // Phase counter: reset/clear to zero, otherwise increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else begin
            count_r <= count_r + 8'd1;
        end
    end

    assign done = (count_r == (duration - 8'd1));

endmodule

// File: rtl/traffic_rtl.sv
// -----------------------------------------------------------------------------
// traffic_rtl
// Four-way intersection traffic-light controller. Moore FSM granting green in
// round-robin order north -> south -> east -> west; all other approaches red.
// Lamp outputs are registered and always equal the decode of the registered
// state, so they are glitch-free and update together with the state.
// Parameters:
//   GREEN_CYCLES   green phase length (1..255)
//   YELLOW_CYCLES  yellow phase length (1..255)
//   ALL_RED_CYCLES clearance length (1..255), only with TRAFFIC_ALL_RED_EN
//   INIT_CYCLES    all-red cycles after reset release (1..255)
// Ports:
//   clock        in  system clock, rising edge
//   reset        in  asynchronous active-low reset
//   north_light  out [2:0] one-hot {red, yellow, green}
//   south_light  out [2:0]
//   east_light   out [2:0]
//   west_light   out [2:0]
// Configuration macro: TRAFFIC_ALL_RED_EN -- when defined, each yellow is
// followed by an all-red clearance phase before the next green.
// -----------------------------------------------------------------------------
module traffic_rtl
    import traffic_pkg::*;
#(
    parameter int GREEN_CYCLES   = 8,
    parameter int YELLOW_CYCLES  = 3,
`ifdef TRAFFIC_ALL_RED_EN
    parameter int ALL_RED_CYCLES = 2,
`endif
    parameter int INIT_CYCLES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    output logic [2:0] north_light,
    output logic [2:0] south_light,
    output logic [2:0] east_light,
    output logic [2:0] west_light
);

    localparam logic [7:0] GREEN_DUR  = 8'(GREEN_CYCLES);
    localparam logic [7:0] YELLOW_DUR = 8'(YELLOW_CYCLES);
    localparam logic [7:0] INIT_DUR   = 8'(INIT_CYCLES);
`ifdef TRAFFIC_ALL_RED_EN
    localparam logic [7:0] CLR_DUR    = 8'(ALL_RED_CYCLES);
`endif

    state_e      state_r;
    state_e      state_next_s;
    logic [11:0] lamps_r;
    logic [7:0]  duration_s;
    logic        done_s;
    logic        clear_s;
    dir_e        dir_s;

    assign dir_s = dir_of(state_r);

    // Phase length for the current state; illegal states get one cycle.
    always_comb begin
        duration_s = 8'd1;
        case (state_r)
            INIT:                                      duration_s = INIT_DUR;
            N_GREEN, S_GREEN, E_GREEN, W_GREEN:        duration_s = GREEN_DUR;
            N_YELLOW, S_YELLOW, E_YELLOW, W_YELLOW:    duration_s = YELLOW_DUR;
`ifdef TRAFFIC_ALL_RED_EN
            N_CLR, S_CLR, E_CLR, W_CLR:                duration_s = CLR_DUR;
`endif
            default:                                   duration_s = 8'd1;
        endcase
    end

    // Next-state logic; an unrecognised encoding falls back to INIT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            INIT: begin
                if (done_s) state_next_s = N_GREEN;
                else        state_next_s = state_r;
            end
            N_GREEN, S_GREEN, E_GREEN, W_GREEN: begin
                if (done_s) state_next_s = yellow_state(dir_s);
                else        state_next_s = state_r;
            end
            N_YELLOW, S_YELLOW, E_YELLOW, W_YELLOW: begin
`ifdef TRAFFIC_ALL_RED_EN
                if (done_s) state_next_s = clr_state(dir_s);
                else        state_next_s = state_r;
`else
                if (done_s) state_next_s = green_state(next_dir(dir_s));
                else        state_next_s = state_r;
`endif
            end
`ifdef TRAFFIC_ALL_RED_EN
            N_CLR, S_CLR, E_CLR, W_CLR: begin
                if (done_s) state_next_s = green_state(next_dir(dir_s));
                else        state_next_s = state_r;
            end
`endif
            default: state_next_s = INIT;
        endcase
    end

    // Any state change restarts the phase count from zero.
    assign clear_s = (state_next_s != state_r);

    traffic_phase_timer u_timer (
        .clk      (clock),
        .rst_n    (reset),
        .clear    (clear_s),
        .duration (duration_s),
        .done     (done_s)
    );

    // State register plus lamp register decoded from the next state, so the
    // lamps always match the state held in state_r.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= INIT;
            lamps_r <= LAMPS_ALL_RED;
        end else begin
            state_r <= state_next_s;
            lamps_r <= lamps_of(state_next_s);
        end
    end

    assign north_light = lamps_r[11:9];
    assign south_light = lamps_r[8:6];
    assign east_light  = lamps_r[5:3];
    assign west_light  = lamps_r[2:0];

endmodule

// File: tb/tb_traffic_rtl.sv
// -----------------------------------------------------------------------------
// tb_traffic_rtl
// Self-checking bench for traffic_rtl. The expected lamp pattern for each
// cycle is computed from the elapsed cycle count since reset release, queued
// when the cycle is driven, and popped and compared after the clock edge.
// Honours TRAFFIC_ALL_RED_EN for the expected clearance phases.
// -----------------------------------------------------------------------------
module tb_traffic_rtl;
    import traffic_pkg::*;

    localparam int G = 8;
    localparam int Y = 3;
    localparam int I = 2;
`ifdef TRAFFIC_ALL_RED_EN
    localparam int C = 2;
`else
    localparam int C = 0;
`endif
    localparam int SEG    = G + Y + C;
    localparam int PERIOD = 4 * SEG;

    logic       clock;
    logic       reset;
    logic [2:0] north_light;
    logic [2:0] south_light;
    logic [2:0] east_light;
    logic [2:0] west_light;

    int          errors;
    int          checks;
    int          t;
    int          last_onset;
    logic        prev_ng;
    logic [11:0] sb[$];

    traffic_rtl dut (
        .clock       (clock),
        .reset       (reset),
        .north_light (north_light),
        .south_light (south_light),
        .east_light  (east_light),
        .west_light  (west_light)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got %h expected %h", tag, t, got, exp);
        end
    endtask

    // Expected {north, south, east, west} after k edges since reset release.
    function automatic logic [11:0] model(input int k);
        logic [11:0] r;
        logic [2:0]  lamp;
        int p, d, w;
        r = {3'b100, 3'b100, 3'b100, 3'b100};
        if (k >= I) begin
            p = (k - I) % PERIOD;
            d = p / SEG;
            w = p % SEG;
            if (w < G)          lamp = 3'b001;
            else if (w < G + Y) lamp = 3'b010;
            else                lamp = 3'b100;
            case (d)
                0:       r[11:9] = lamp;
                1:       r[8:6]  = lamp;
                2:       r[5:3]  = lamp;
                default: r[2:0]  = lamp;
            endcase
        end
        return r;
    endfunction

    function automatic logic [11:0] observed();
        return {north_light, south_light, east_light, west_light};
    endfunction

    task automatic check_safety();
        int active;
        logic [11:0] o;
        o = observed();
        active = 0;
        for (int j = 0; j < 4; j++) begin
            logic [2:0] l;
            l = o[j*3 +: 3];
            check_eq("onehot", {11'd0, $onehot(l)}, 12'd1);
            if (l != 3'b100) active++;
        end
        check_eq("one_active", {11'd0, (active <= 1)}, 12'd1);
    endtask

    task automatic run_cycles(input int n);
        logic [11:0] exp;
        logic        ng;
        for (int i = 0; i < n; i++) begin
            t++;
            sb.push_back(model(t));
            @(posedge clock);
            #1;
            exp = sb.pop_front();
            check_eq("lamps", observed(), exp);
            check_safety();
            ng = (north_light == 3'b001);
            if (ng && !prev_ng) begin
                if (last_onset >= 0) check_eq("period", 12'(t - last_onset), 12'(PERIOD));
                else                 check_eq("first_green", 12'(t), 12'(I));
                last_onset = t;
            end
            prev_ng = ng;
        end
    endtask

    task automatic reset_hold_check(input int edges);
        reset = 1'b0;
        #1;
        check_eq("reset_async", observed(), 12'h924);
        for (int i = 0; i < edges; i++) begin
            @(posedge clock);
            #1;
            check_eq("reset_held", observed(), 12'h924);
        end
        reset = 1'b1;
        t = 0;
        last_onset = -1;
        prev_ng = 1'b0;
        #1;
        check_eq("release", observed(), model(0));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        t = 0;
        last_onset = -1;
        prev_ng = 1'b0;
        reset = 1'b1;
        #2;
        // Assert between edges (first rising edge is at 5).
        reset_hold_check(3);
        run_cycles(500);

        // Restart, advance into E_YELLOW, then reset mid-phase.
        reset_hold_check(2);
        run_cycles(2 * SEG + G + I + 1);
        check_eq("in_e_yellow", {9'd0, east_light}, {9'd0, 3'b010});
        reset_hold_check(2);
        run_cycles(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
